// File: rtl/muladd_pkg.sv
// Shared arithmetic definitions for the sequential multiply-accumulate unit.
// Holds the common operand width (matched with the divider) and the FSM state type.
package muladd_pkg;

  // Operand width shared with the sequential divider.
  localparam int unsigned W = 8;

  // Result / accumulator width.
  localparam int unsigned ACC_W = 2 * W;

  // Iteration counter width, wide enough to hold 0..W.
  localparam int unsigned CNT_W = $clog2(W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : muladd_pkg

// File: rtl/muladd.sv
// Sequential shift-add multiply-accumulate: p = a*b + c, one multiplier bit per clock.
// Closes the loop on divider results (quotient*divisor + remainder = dividend).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - request, sampled only while ready=1
//   a      - multiplicand (W bits)
//   b      - multiplier (W bits)
//   c      - addend, zero-extended (W bits)
//   p      - result a*b+c (2W bits), valid while ready=1
//   ready  - 1 = idle with p holding the last result, 0 = computing
module muladd
  import muladd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  output logic [ACC_W-1:0] p,
  output logic             ready
);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   p_q, p_d;
  logic               ready_q, ready_d;

  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_sum;

  // One partial product per RUN cycle; b_q is shifted so bit 0 is always the current bit.
  always_comb begin
    addend  = b_q[0] ? (ACC_W'(a_q) << cnt_q) : '0;
    acc_sum = acc_q + addend;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ready_d = ready_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = ACC_W'(c);
          cnt_d   = '0;
          state_d = RUN;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // p is only written here, so it never shows a partial sum.
        if (cnt_q == CNT_W'(W - 1)) begin
          p_d     = acc_sum;
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign p     = p_q;
  assign ready = ready_q;

endmodule : muladd

// File: tb/tb_muladd.sv
// Directed and random checks for the sequential multiply-accumulate unit.
module tb_muladd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
  logic [15:0] p;
  logic        ready;

  int unsigned tests;
  int unsigned fails;
  logic [15:0] prev_p;

  muladd dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .p     (p),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] observed, input logic [31:0] expected, input string tag);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one request, optionally pulse start mid-run, and check busy length and result.
  task automatic op(input logic [7:0] ai, input logic [7:0] bi, input logic [7:0] ci,
                    input logic [15:0] exp, input bit mid_pulse, input string tag);
    int busy;
    @(negedge clk);
    a = ai; b = bi; c = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ai; b = ~bi; c = ~ci;
    busy = 0;
    while (ready !== 1'b1 && busy < 20) begin
      chk(32'(p), 32'(prev_p), {tag, "_p_hold"});
      if (mid_pulse && busy == 3) begin
        start = 1'b1; a = 8'd200; b = 8'd100; c = 8'd50;
      end else begin
        start = 1'b0;
      end
      busy++;
      @(negedge clk);
    end
    chk(32'(busy), 32'd8, {tag, "_busy"});
    chk(32'(p), 32'(exp), {tag, "_p"});
    prev_p = exp;
  endtask

  initial begin
    logic [7:0] ra, rb, rc;
    tests  = 0;
    fails  = 0;
    prev_p = 16'd0;
    reset  = 1'b1;
    start  = 1'b0;
    a = '0; b = '0; c = '0;

    repeat (3) @(negedge clk);
    chk(32'(ready), 32'd1, "reset_ready");
    chk(32'(p), 32'd0, "reset_p");
    reset = 1'b0;

    op(8'd1,   8'd23,  8'd22,  16'd45,    1'b0, "div_45_23");
    op(8'd3,   8'd2,   8'd1,   16'd7,     1'b0, "small");
    op(8'd255, 8'd255, 8'd255, 16'd65280, 1'b0, "max");
    op(8'd0,   8'd0,   8'd0,   16'd0,     1'b0, "zero");
    op(8'd12,  8'd13,  8'd4,   16'd160,   1'b1, "mid_start");

    // Continuous start: a new result every 9 cycles, p stable in between.
    @(negedge clk);
    chk(32'(ready), 32'd1, "mid_start_not_queued");
    a = 8'd5; b = 8'd6; c = 8'd7; start = 1'b1;
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      chk(32'(ready), (j % 9 == 8) ? 32'd1 : 32'd0, "hold_ready");
      chk(32'(p), (j < 8) ? 32'(prev_p) : 32'd37, "hold_p");
    end
    start = 1'b0;
    prev_p = 16'd37;
    @(negedge clk);
    chk(32'(ready), 32'd1, "hold_release");

    // Reset four cycles into RUN aborts the operation.
    a = 8'd99; b = 8'd77; c = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(ready), 32'd0, "abort_busy");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk(32'(ready), 32'd1, "abort_ready");
    chk(32'(p), 32'd0, "abort_p");
    prev_p = 16'd0;
    repeat (10) @(negedge clk);
    chk(32'(p), 32'd0, "abort_no_result");

    // Reset and start on the same edge: start is dropped.
    a = 8'd9; b = 8'd9; c = 8'd9; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk(32'(ready), 32'd1, "rst_start_ready");
    @(negedge clk);
    chk(32'(ready), 32'd1, "rst_start_dropped");

    op(8'd10, 8'd10, 8'd0, 16'd100, 1'b0, "after_abort");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      op(ra, rb, rc, 16'(ra) * 16'(rb) + 16'(rc), 1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_muladd

// File: doc/muladd.md
# muladd

Sequential shift-add multiply-accumulate unit computing p = a·b + c, one multiplier bit per clock. It is the inverse companion of the sequential divider: feeding back a divider's quotient, divisor and remainder reconstructs the dividend, so benches and datapaths can close the loop on division results. It uses the same start/ready handshake style as the divider.

## Interface

- W, 8, operand width; the result is 2·W bits wide.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- a  input  W  multiplicand (e.g. divider quotient)
- b  input  W  multiplier (e.g. divider divisor)
- c  input  W  addend, zero-extended (e.g. divider remainder)
- p  output  2·W  result a·b + c, valid while ready=1
- ready  output  1  1 = idle and p holds last result; 0 = computing

## Operation

- States: IDLE (ready=1) and RUN (ready=0).
- Reset (synchronous, has priority over everything): state IDLE, ready=1, p=0, internal registers cleared.
- In IDLE, when start=1 at a clock edge:
  - latch a_r=a, b_r=b;
  - set acc = {W'b0, c};
  - set cnt = 0;
  - enter RUN.
- In IDLE with start=0: hold state; p is unchanged.
- Each edge in RUN (iteration i = cnt, 0..W-1):
  - if b_r[0]=1: acc += a_r << i;
  - shift b_r right by 1;
  - cnt += 1.
- On the edge that completes iteration W-1: p ← final acc, state → IDLE, ready → 1.
- Arithmetic is unsigned and cannot overflow: the maximum is (2^W−1)² + 2^W−1 = 2^2W − 2^W, which fits in 2·W bits.
- p updates only at completion. It keeps the previous result throughout RUN and is never a partial sum.
- start during RUN is ignored. It is not queued and inputs are not re-latched.
- Inputs a/b/c may change freely after the accepting edge.
- No early termination: b=0 or a=0 still takes the full W iterations.

## Timing

- Edge k samples start=1 in IDLE. From edge k to edge k+W, ready=0.
- After edge k+W: ready=1 and p is valid. Latency is W+1 edges from the accepting edge (9 for W=8); ready is low for exactly W cycles.
- Back-to-back: start held or reasserted in the first cycle ready=1 is accepted on that edge. Throughput is one result per W+1 cycles.
- A start pulse that lasts several cycles while ready=1 is accepted once. It is re-accepted only if still high when ready returns to 1.
- Reset asserted mid-RUN:
  - the operation is aborted;
  - after the reset edge: ready=1, p=0;
  - no result from the aborted operation ever appears.
- reset and start high on the same edge: reset wins and start is dropped.

## Structure

- The shared arithmetic package holds:
  - the state enum {IDLE, RUN};
  - the default width constant W=8, shared with the divider so both agree on operand width.
- cnt is $clog2(W+1) bits wide. acc is 2·W bits wide.
- Single module with no sub-module. The datapath is one adder plus shifters, too small to split.

## Test plan

- Reset 3 cycles. Then a=1, b=23, c=22, start for 1 cycle → ready low 8 cycles, then ready=1 with p=45. This is the divider's 45/23 case closed.
- a=3, b=2, c=1 → p=7 after 9 edges. Then a=255, b=255, c=255 → p=65280 (no overflow). Then a=0, b=0, c=0 → p=0, still with 8-cycle busy.
- Pulse start again mid-RUN with different operands → ignored: original result delivered on schedule, ready timing unchanged.
- Hold start high continuously with a=5, b=6, c=7 → p=37 each time, results every 9 cycles, p stable between completions.
- Assert reset 4 cycles into RUN → next cycle ready=1, p=0. A new request a=10, b=10, c=0 then yields p=100.
- Random sweep of 1000 operand triples against the reference model a·b+c, checking exact ready latency for each.
